reset_sequencer: RTL and testbench

Ordered reset release controller between the power-on/debounced reset generator and the board subsystems: flash, SDRAM controller, peripherals, CPU. On power-up it releases each domain in a fixed order with millisecond-scale dwell times and waits for the SDRAM controller's init handshake, with a timeout. It also runs a CPU/peripheral-only soft-reset sequence on request.

---
 rtl/reset_sequencer.sv | 159 +++++++++++++++
 tb/tb_reset_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered reset release for flash, SDRAM controller,
// peripherals and CPU. Each stage dwells for a whole number of "steps"
// (STEP_CYCLES clocks each) before the next domain is released. The SDRAM
// stage waits for the controller's init handshake, with a timeout.
// A CPU/peripheral-only soft reset can be run from S_RUN.
// SEQ_STATE exposes the FSM state for debug and checkers.
module reset_sequencer #(
    parameter int STEP_CYCLES     = 50000,
    parameter int HOLD_STEPS      = 2,
    parameter int FLASH_STEPS     = 1,
    parameter int SDRAM_TMO_STEPS = 200,
    parameter int SOFT_STEPS      = 1
) (
    input  logic       CLK,
    input  logic       SYS_RESET_N,
    input  logic       RESET_IN_N,
    input  logic       SOFT_RESET_REQ,
    input  logic       SDRAM_INIT_DONE,
    output logic       FLASH_RESET_N,
    output logic       SDRAM_RESET_N,
    output logic       PERIPH_RESET_N,
    output logic       CPU_RESET_N,
    output logic       SEQ_DONE,
    output logic [2:0] SEQ_STATE,
    output logic       SDRAM_TIMEOUT
);

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_FLASH  = 3'd1,
        S_SDRAM  = 3'd2,
        S_PERIPH = 3'd3,
        S_RUN    = 3'd4,
        S_SOFT   = 3'd5
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(STEP_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [15:0] presc;
    logic [15:0] presc_nx;
    logic [7:0]  steps;
    logic [7:0]  steps_nx;
    logic        tmo_nx;

    logic [1:0]  rin_sync;
    logic [1:0]  done_sync;
    logic [2:0]  req_sync;

    logic        rin_ok;
    logic        done_ok;
    logic        soft_rise;
    logic [7:0]  dwell_last;
    logic        step_end;

    assign rin_ok    = rin_sync[1];
    assign done_ok   = done_sync[1];
    // Third stage only serves the edge detector; the FSM acts on stage two.
    assign soft_rise = req_sync[1] & ~req_sync[2];
    assign SEQ_STATE = state;

    // Two-flop synchronizers for the asynchronous inputs, plus an edge stage for the request.
    always_ff @(posedge CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            rin_sync  <= 2'b00;
            done_sync <= 2'b00;
            req_sync  <= 3'b000;
        end else begin
            rin_sync  <= {rin_sync[0], RESET_IN_N};
            done_sync <= {done_sync[0], SDRAM_INIT_DONE};
            req_sync  <= {req_sync[1:0], SOFT_RESET_REQ};
        end
    end

    // Last step index of the current state's dwell (dwell N -> index N-1).
    always_comb begin
        dwell_last = 8'd0;
        case (state)
            S_HOLD:   dwell_last = 8'(HOLD_STEPS - 1);
            S_FLASH:  dwell_last = 8'(FLASH_STEPS - 1);
            S_SDRAM:  dwell_last = 8'(SDRAM_TMO_STEPS - 1);
            S_PERIPH: dwell_last = 8'd0;
            S_SOFT:   dwell_last = 8'(SOFT_STEPS - 1);
            default:  dwell_last = 8'd0;
        endcase
    end

    assign step_end = (presc == PRESC_LAST) && (steps == dwell_last);

    // Next-state, timeout flag and step timer; a low synced RESET_IN_N overrides everything.
    always_comb begin
        state_nx = state;
        tmo_nx   = SDRAM_TIMEOUT;
        if (!rin_ok) begin
            state_nx = S_HOLD;
        end else begin
            case (state)
                S_HOLD:   if (step_end) state_nx = S_FLASH;
                S_FLASH:  if (step_end) state_nx = S_SDRAM;
                S_SDRAM: begin
                    // Init-done takes precedence over a coincident timeout.
                    if (done_ok) begin
                        state_nx = S_PERIPH;
                    end else if (step_end) begin
                        state_nx = S_PERIPH;
                        tmo_nx   = 1'b1;
                    end
                end
                S_PERIPH: if (step_end) state_nx = S_RUN;
                S_RUN:    if (soft_rise) state_nx = S_SOFT;
                S_SOFT:   if (step_end) state_nx = S_PERIPH;
                default:  state_nx = S_HOLD;
            endcase
        end
        if (state_nx == S_HOLD) begin
            tmo_nx = 1'b0;
        end

        // Timer restarts on every state change, stays idle in S_RUN and
        // while the upstream reset is asserted.
        if ((state_nx != state) || !rin_ok || (state == S_RUN)) begin
            presc_nx = 16'd0;
            steps_nx = 8'd0;
        end else if (presc == PRESC_LAST) begin
            presc_nx = 16'd0;
            steps_nx = steps + 8'd1;
        end else begin
            presc_nx = presc + 16'd1;
            steps_nx = steps;
        end
    end

    // State, timer and outputs; outputs are decoded from the next state so they move with it.
    always_ff @(posedge CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            state          <= S_HOLD;
            presc          <= 16'd0;
            steps          <= 8'd0;
            SDRAM_TIMEOUT  <= 1'b0;
            FLASH_RESET_N  <= 1'b0;
            SDRAM_RESET_N  <= 1'b0;
            PERIPH_RESET_N <= 1'b0;
            CPU_RESET_N    <= 1'b0;
            SEQ_DONE       <= 1'b0;
        end else begin
            state          <= state_nx;
            presc          <= presc_nx;
            steps          <= steps_nx;
            SDRAM_TIMEOUT  <= tmo_nx;
            FLASH_RESET_N  <= (state_nx != S_HOLD);
            SDRAM_RESET_N  <= (state_nx inside {S_SDRAM, S_PERIPH, S_RUN, S_SOFT});
            PERIPH_RESET_N <= (state_nx inside {S_PERIPH, S_RUN});
            CPU_RESET_N    <= (state_nx == S_RUN);
            SEQ_DONE       <= (state_nx == S_RUN);
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer. The reference model tracks the sequence as a
// phase plus a remaining-clock countdown, and applies input latency by
// looking up per-edge input history.
module tb_reset_sequencer;

    localparam int STEP = 4;
    localparam int HOLD = 2;
    localparam int FLS  = 1;
    localparam int TMO  = 3;
    localparam int SOFT = 1;
    localparam int HMAX = 4096;

    localparam int MS_HOLD   = 0;
    localparam int MS_FLASH  = 1;
    localparam int MS_SDRAM  = 2;
    localparam int MS_PERIPH = 3;
    localparam int MS_RUN    = 4;
    localparam int MS_SOFT   = 5;

    logic       CLK = 1'b0;
    logic       SYS_RESET_N = 1'b0;
    logic       RESET_IN_N = 1'b0;
    logic       SOFT_RESET_REQ = 1'b0;
    logic       SDRAM_INIT_DONE = 1'b0;
    logic       FLASH_RESET_N;
    logic       SDRAM_RESET_N;
    logic       PERIPH_RESET_N;
    logic       CPU_RESET_N;
    logic       SEQ_DONE;
    logic [2:0] SEQ_STATE;
    logic       SDRAM_TIMEOUT;

    reset_sequencer #(
        .STEP_CYCLES(STEP), .HOLD_STEPS(HOLD), .FLASH_STEPS(FLS),
        .SDRAM_TMO_STEPS(TMO), .SOFT_STEPS(SOFT)
    ) dut (
        .CLK(CLK), .SYS_RESET_N(SYS_RESET_N), .RESET_IN_N(RESET_IN_N),
        .SOFT_RESET_REQ(SOFT_RESET_REQ), .SDRAM_INIT_DONE(SDRAM_INIT_DONE),
        .FLASH_RESET_N(FLASH_RESET_N), .SDRAM_RESET_N(SDRAM_RESET_N),
        .PERIPH_RESET_N(PERIPH_RESET_N), .CPU_RESET_N(CPU_RESET_N),
        .SEQ_DONE(SEQ_DONE), .SEQ_STATE(SEQ_STATE), .SDRAM_TIMEOUT(SDRAM_TIMEOUT)
    );

    // ---------------- clock / reset ----------------
    bit clk_en = 1'b1;
    always begin
        #5;
        if (clk_en) CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    int edge_n;
    bit rin_h [HMAX];
    bit done_h[HMAX];
    bit req_h [HMAX];
    int m_state;
    int m_left;
    bit m_tmo;
    int t_flash, t_sdram, t_periph, t_cpu, t_done, t_tmo;

    function automatic bit rin_at(input int e);
        if (e < 1 || e >= HMAX) return 1'b0;
        return rin_h[e];
    endfunction
    function automatic bit done_at(input int e);
        if (e < 1 || e >= HMAX) return 1'b0;
        return done_h[e];
    endfunction
    function automatic bit req_at(input int e);
        if (e < 1 || e >= HMAX) return 1'b0;
        return req_h[e];
    endfunction

    function automatic int dwell_of(input int s);
        case (s)
            MS_HOLD:   return HOLD * STEP;
            MS_FLASH:  return FLS * STEP;
            MS_SDRAM:  return TMO * STEP;
            MS_PERIPH: return STEP;
            MS_SOFT:   return SOFT * STEP;
            default:   return 0;
        endcase
    endfunction

    task automatic m_enter(input int s);
        m_state = s;
        m_left  = dwell_of(s);
    endtask

    // Inputs sampled at edge e take effect at edge e+2.
    task automatic model_edge();
        bit rin_u, done_u, rise;
        rin_u  = rin_at(edge_n - 2);
        done_u = done_at(edge_n - 2);
        rise   = req_at(edge_n - 2) && !req_at(edge_n - 3);
        if (!rin_u) begin
            m_enter(MS_HOLD);
            m_tmo = 1'b0;
        end else begin
            case (m_state)
                MS_HOLD:   begin m_left--; if (m_left == 0) m_enter(MS_FLASH);  end
                MS_FLASH:  begin m_left--; if (m_left == 0) m_enter(MS_SDRAM);  end
                MS_SDRAM: begin
                    if (done_u) m_enter(MS_PERIPH);
                    else begin
                        m_left--;
                        if (m_left == 0) begin m_tmo = 1'b1; m_enter(MS_PERIPH); end
                    end
                end
                MS_PERIPH: begin m_left--; if (m_left == 0) m_enter(MS_RUN);    end
                MS_RUN:    if (rise) m_enter(MS_SOFT);
                MS_SOFT:   begin m_left--; if (m_left == 0) m_enter(MS_PERIPH); end
                default:   m_enter(MS_HOLD);
            endcase
        end
    endtask

    function automatic logic [8:0] exp_vec();
        logic f, s, p, c;
        f = (m_state != MS_HOLD);
        s = (m_state inside {MS_SDRAM, MS_PERIPH, MS_RUN, MS_SOFT});
        p = (m_state inside {MS_PERIPH, MS_RUN});
        c = (m_state == MS_RUN);
        return {f, s, p, c, c, 3'(m_state), m_tmo};
    endfunction

    function automatic logic [8:0] act_vec();
        return {FLASH_RESET_N, SDRAM_RESET_N, PERIPH_RESET_N, CPU_RESET_N,
                SEQ_DONE, SEQ_STATE, SDRAM_TIMEOUT};
    endfunction

    // ---------------- driver tasks ----------------
    // Releases SYS_RESET_N between edges; the next posedge is edge 1.
    task automatic do_release();
        edge_n = 0;
        m_enter(MS_HOLD);
        m_tmo = 1'b0;
        t_flash = -1; t_sdram = -1; t_periph = -1; t_cpu = -1; t_done = -1; t_tmo = -1;
        #2;
        SYS_RESET_N = 1'b1;
    endtask

    task automatic pulse_sys_reset();
        SYS_RESET_N = 1'b0;
        #1;
        do_release();
    endtask

    // One clock edge: record inputs, step the model, then settle before sampling.
    task automatic tick();
        @(posedge CLK);
        edge_n++;
        if (edge_n < HMAX) begin
            rin_h[edge_n]  = RESET_IN_N;
            done_h[edge_n] = SDRAM_INIT_DONE;
            req_h[edge_n]  = SOFT_RESET_REQ;
        end
        model_edge();
        #1;
        if (t_flash  < 0 && FLASH_RESET_N)  t_flash  = edge_n;
        if (t_sdram  < 0 && SDRAM_RESET_N)  t_sdram  = edge_n;
        if (t_periph < 0 && PERIPH_RESET_N) t_periph = edge_n;
        if (t_cpu    < 0 && CPU_RESET_N)    t_cpu    = edge_n;
        if (t_done   < 0 && SEQ_DONE)       t_done   = edge_n;
        if (t_tmo    < 0 && SDRAM_TIMEOUT)  t_tmo    = edge_n;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET_IN_N = 1'b1;
        SDRAM_INIT_DONE = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (act_vec() !== 9'd0) begin
            n_bad++; $display("FAIL reset_state: got %b want %b", act_vec(), 9'd0);
        end
        do_release();
    endtask

    task automatic test_power_on();
        for (int i = 0; i < 22; i++) begin
            tick();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL po_model e%0d: got %b want %b", edge_n, act_vec(), exp_vec());
            end
        end
        n_cmp++; if (t_flash !== 10)  begin n_bad++; $display("FAIL po_flash_edge: got %0d want 10", t_flash); end
        n_cmp++; if (t_sdram !== 14)  begin n_bad++; $display("FAIL po_sdram_edge: got %0d want 14", t_sdram); end
        n_cmp++; if (t_periph !== 15) begin n_bad++; $display("FAIL po_periph_edge: got %0d want 15", t_periph); end
        n_cmp++; if (t_cpu !== 19)    begin n_bad++; $display("FAIL po_cpu_edge: got %0d want 19", t_cpu); end
        n_cmp++; if (t_done !== 19)   begin n_bad++; $display("FAIL po_done_edge: got %0d want 19", t_done); end
        n_cmp++; if (SEQ_STATE !== 3'd4) begin n_bad++; $display("FAIL po_state: got %0d want 4", SEQ_STATE); end
        n_cmp++; if (SDRAM_TIMEOUT !== 1'b0) begin n_bad++; $display("FAIL po_tmo: got %b want 0", SDRAM_TIMEOUT); end
    endtask

    task automatic test_timeout();
        SDRAM_INIT_DONE = 1'b0;
        pulse_sys_reset();
        for (int i = 0; i < 32; i++) begin
            tick();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL tmo_model e%0d: got %b want %b", edge_n, act_vec(), exp_vec());
            end
        end
        n_cmp++; if (t_periph !== 26) begin n_bad++; $display("FAIL tmo_periph_edge: got %0d want 26", t_periph); end
        n_cmp++; if (t_tmo !== 26)    begin n_bad++; $display("FAIL tmo_flag_edge: got %0d want 26", t_tmo); end
        n_cmp++; if (t_cpu !== 30)    begin n_bad++; $display("FAIL tmo_cpu_edge: got %0d want 30", t_cpu); end
        SDRAM_INIT_DONE = 1'b1;
    endtask

    task automatic test_soft();
        int k;
        k = edge_n + 1;
        SOFT_RESET_REQ = 1'b1;
        tick();
        SOFT_RESET_REQ = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL soft_model e%0d: got %b want %b", edge_n, act_vec(), exp_vec());
            end
            n_cmp++;
            if ({FLASH_RESET_N, SDRAM_RESET_N} !== 2'b11) begin
                n_bad++; $display("FAIL soft_flash_sdram e%0d: got %b want 11", edge_n, {FLASH_RESET_N, SDRAM_RESET_N});
            end
            if (edge_n == k + 2) begin
                n_cmp++;
                if ({CPU_RESET_N, PERIPH_RESET_N, SEQ_STATE} !== 5'b00_101) begin
                    n_bad++; $display("FAIL soft_enter: got %b want 00101", {CPU_RESET_N, PERIPH_RESET_N, SEQ_STATE});
                end
            end
            if (edge_n == k + 5 || edge_n == k + 6) begin
                n_cmp++;
                if (PERIPH_RESET_N !== (edge_n == k + 6)) begin
                    n_bad++; $display("FAIL soft_periph e%0d: got %b want %b", edge_n, PERIPH_RESET_N, edge_n == k + 6);
                end
            end
            if (edge_n == k + 9 || edge_n == k + 10) begin
                n_cmp++;
                if (CPU_RESET_N !== (edge_n == k + 10)) begin
                    n_bad++; $display("FAIL soft_cpu e%0d: got %b want %b", edge_n, CPU_RESET_N, edge_n == k + 10);
                end
            end
        end
    endtask

    task automatic test_reset_in_drop();
        int k, r;
        // From S_RUN with the timeout flag set: drop forces S_HOLD and clears it.
        k = edge_n + 1;
        RESET_IN_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL drop_run_model e%0d: got %b want %b", edge_n, act_vec(), exp_vec());
            end
            if (edge_n == k + 2) begin
                n_cmp++;
                if (act_vec() !== 9'd0) begin
                    n_bad++; $display("FAIL drop_run_outputs: got %b want 0", act_vec());
                end
            end
        end
        // Restart with no init-done, then drop again inside S_SDRAM.
        SDRAM_INIT_DONE = 1'b0;
        RESET_IN_N = 1'b1;
        r = edge_n + 1;
        k = r + 16;
        for (int i = 0; i < 20; i++) begin
            if (edge_n == k - 1) RESET_IN_N = 1'b0;
            tick();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL drop_sdram_model e%0d: got %b want %b", edge_n, act_vec(), exp_vec());
            end
            if (edge_n == k + 1) begin
                n_cmp++;
                if (SEQ_STATE !== 3'd2) begin n_bad++; $display("FAIL drop_sdram_pre: got %0d want 2", SEQ_STATE); end
            end
            if (edge_n == k + 2) begin
                n_cmp++;
                if (act_vec() !== 9'd0) begin n_bad++; $display("FAIL drop_sdram_outputs: got %b want 0", act_vec()); end
            end
        end
        // Replay the full sequence with init-done present.
        SDRAM_INIT_DONE = 1'b1;
        RESET_IN_N = 1'b1;
        r = edge_n + 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL replay_model e%0d: got %b want %b", edge_n, act_vec(), exp_vec());
            end
            if (edge_n == r + 17 || edge_n == r + 18) begin
                n_cmp++;
                if (CPU_RESET_N !== (edge_n == r + 18)) begin
                    n_bad++; $display("FAIL replay_cpu e%0d: got %b want %b", edge_n, CPU_RESET_N, edge_n == r + 18);
                end
            end
        end
        n_cmp++;
        if (SDRAM_TIMEOUT !== 1'b0) begin n_bad++; $display("FAIL replay_tmo: got %b want 0", SDRAM_TIMEOUT); end
    endtask

    task automatic test_async_reset();
        clk_en = 1'b0;
        #2;
        SYS_RESET_N = 1'b0;
        #1;
        n_cmp++;
        if (act_vec() !== 9'd0) begin n_bad++; $display("FAIL async_reset: got %b want 0", act_vec()); end
        #20;
        clk_en = 1'b1;
        @(posedge CLK);
        #1;
        do_release();
    endtask

    task automatic test_soft_ignored();
        bit saw_soft;
        int k;
        saw_soft = 1'b0;
        for (int i = 0; i < 30; i++) begin
            SOFT_RESET_REQ = (edge_n == 10);
            tick();
            if (SEQ_STATE == 3'd5) saw_soft = 1'b1;
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL ign_model e%0d: got %b want %b", edge_n, act_vec(), exp_vec());
            end
        end
        SOFT_RESET_REQ = 1'b0;
        n_cmp++;
        if ({saw_soft, SEQ_STATE} !== 4'b0_100) begin
            n_bad++; $display("FAIL ign_no_soft: got %b want 0100", {saw_soft, SEQ_STATE});
        end
        // Request and upstream reset drop on the same edge: reset wins.
        k = edge_n + 1;
        SOFT_RESET_REQ = 1'b1;
        RESET_IN_N = 1'b0;
        tick();
        SOFT_RESET_REQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL both_model e%0d: got %b want %b", edge_n, act_vec(), exp_vec());
            end
            if (edge_n >= k + 2) begin
                n_cmp++;
                if (SEQ_STATE !== 3'd0) begin n_bad++; $display("FAIL both_hold e%0d: got %0d want 0", edge_n, SEQ_STATE); end
            end
        end
        RESET_IN_N = 1'b1;
    endtask

    task automatic test_random();
        RESET_IN_N = 1'b1;
        SDRAM_INIT_DONE = 1'b0;
        pulse_sys_reset();
        for (int i = 0; i < 1500; i++) begin
            if (RESET_IN_N) RESET_IN_N = ($urandom_range(0, 149) != 0);
            else            RESET_IN_N = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 29) == 0) SDRAM_INIT_DONE = ~SDRAM_INIT_DONE;
            if (SOFT_RESET_REQ) SOFT_RESET_REQ = ($urandom_range(0, 3) == 0);
            else                SOFT_RESET_REQ = ($urandom_range(0, 11) == 0);
            tick();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL rand_model e%0d: got %b want %b", edge_n, act_vec(), exp_vec());
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        #2;
        n_cmp++;
        if (act_vec() !== 9'd0) begin n_bad++; $display("FAIL init_reset: got %b want 0", act_vec()); end
        test_reset();
        test_power_on();
        test_timeout();
        test_soft();
        test_reset_in_drop();
        test_async_reset();
        test_soft_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
